// File: rtl/register_file_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : register_file_pkg                                            |
// | Purpose : Shared default sizes and a log2 helper for the register      |
// |           file slice (package, interface, read port, top).             |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package register_file_pkg;

  localparam int c_default_width   = 16;
  localparam int c_default_depth   = 8;
  localparam int c_default_sources = 4;

  // Ceiling log2; exact for the power-of-two sizes this block accepts.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : register_file_if                                             |
// | Purpose : Bundles the write bus and both read ports of register_file.  |
// | Ports   : load, select, in, waddr, clear  - write side                 |
// |           raddr_a, raddr_b                - read addresses             |
// |           out_a, out_b, valid_a, valid_b  - registered read results    |
// |           modport master drives requests, modport slave is the DUT.    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int WIDTH   = c_default_width,
  parameter int DEPTH   = c_default_depth,
  parameter int SOURCES = c_default_sources
);
  localparam int AW = log2(DEPTH);
  localparam int SW = log2(SOURCES);

  logic                       load;
  logic [SW-1:0]              select;
  logic [SOURCES*WIDTH-1:0]   in;
  logic [AW-1:0]              waddr;
  logic                       clear;
  logic [AW-1:0]              raddr_a;
  logic [AW-1:0]              raddr_b;
  logic [WIDTH-1:0]           out_a;
  logic [WIDTH-1:0]           out_b;
  logic                       valid_a;
  logic                       valid_b;

  modport master (
    output load, select, in, waddr, clear, raddr_a, raddr_b,
    input  out_a, out_b, valid_a, valid_b
  );

  modport slave (
    input  load, select, in, waddr, clear, raddr_a, raddr_b,
    output out_a, out_b, valid_a, valid_b
  );

endinterface
`default_nettype wire

// File: rtl/register_file_read_port.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : register_file_read_port                                      |
// | Purpose : One registered read port: selects an entry and its valid     |
// |           bit, optionally forwarding a same-cycle write.               |
// | Ports   : clock, reset (async, active-high)                            |
// |           entries, valids - current storage contents                   |
// |           raddr           - entry to read                              |
// |           load, clear, waddr, wdata - write bus (bypass build only)    |
// |           out, valid      - registered read data and valid flag        |
// | Config  : REGISTER_FILE_BYPASS_EN selects write-through on collision;  |
// |           otherwise the port returns pre-write contents.               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter  int WIDTH = c_default_width,
  parameter  int DEPTH = c_default_depth,
  localparam int AW    = log2(DEPTH)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DEPTH-1:0][WIDTH-1:0] entries,
  input  logic [DEPTH-1:0]            valids,
  input  logic [AW-1:0]               raddr,
`ifdef REGISTER_FILE_BYPASS_EN
  input  logic                        load,
  input  logic                        clear,
  input  logic [AW-1:0]               waddr,
  input  logic [WIDTH-1:0]            wdata,
`endif
  output logic [WIDTH-1:0]            out,
  output logic                        valid
);

  logic [WIDTH-1:0] w_data;
  logic             w_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;

  always_comb begin
    w_data  = entries[raddr];
    w_valid = valids[raddr];
`ifdef REGISTER_FILE_BYPASS_EN
    // Forward the incoming write; otherwise reflect the post-edge valid
    // state, which a concurrent clear drops to zero.
    if (load && (raddr == waddr)) begin
      w_data  = wdata;
      w_valid = 1'b1;
    end else if (clear) begin
      w_valid = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_out   <= w_data;
      r_valid <= w_valid;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : register_file                                                |
// | Purpose : DEPTH x WIDTH register file with a SOURCES-way write mux,    |
// |           per-entry valid bits, synchronous clear and two registered   |
// |           read ports.                                                  |
// | Ports   : clock  - rising-edge clock                                   |
// |           reset  - asynchronous, active-high                           |
// |           bus    - register_file_if.slave (write bus + read ports)     |
// | Config  : REGISTER_FILE_BYPASS_EN enables write-through on read/write  |
// |           collisions (default build returns pre-write contents).       |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module register_file
  import register_file_pkg::*;
#(
  parameter  int WIDTH   = c_default_width,
  parameter  int DEPTH   = c_default_depth,
  parameter  int SOURCES = c_default_sources,
  localparam int AW      = log2(DEPTH),
  localparam int SW      = log2(SOURCES)
) (
  input  logic          clock,
  input  logic          reset,
  register_file_if.slave bus
);

  logic [WIDTH-1:0]            w_sources [SOURCES];
  logic [SW-1:0]               w_select;
  logic [AW-1:0]               w_waddr;
  logic [WIDTH-1:0]            w_wdata;
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [DEPTH-1:0]            r_valid;

  // Unpack the source bus so the mux is a plain indexed read.
  for (genvar k = 0; k < SOURCES; k++) begin : g_src
    assign w_sources[k] = bus.in[k*WIDTH +: WIDTH];
  end

  assign w_select = bus.select;
  assign w_waddr  = bus.waddr;
  assign w_wdata  = w_sources[w_select];

  // Clear is applied first so a same-cycle write re-validates its entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem   <= '0;
      r_valid <= '0;
    end else begin
      if (bus.clear) begin
        r_valid <= '0;
      end
      if (bus.load) begin
        r_mem[w_waddr]   <= w_wdata;
        r_valid[w_waddr] <= 1'b1;
      end
    end
  end

  register_file_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_port_a (
    .clock   (clock),
    .reset   (reset),
    .entries (r_mem),
    .valids  (r_valid),
    .raddr   (bus.raddr_a),
`ifdef REGISTER_FILE_BYPASS_EN
    .load    (bus.load),
    .clear   (bus.clear),
    .waddr   (w_waddr),
    .wdata   (w_wdata),
`endif
    .out     (bus.out_a),
    .valid   (bus.valid_a)
  );

  register_file_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_port_b (
    .clock   (clock),
    .reset   (reset),
    .entries (r_mem),
    .valids  (r_valid),
    .raddr   (bus.raddr_b),
`ifdef REGISTER_FILE_BYPASS_EN
    .load    (bus.load),
    .clear   (bus.clear),
    .waddr   (w_waddr),
    .wdata   (w_wdata),
`endif
    .out     (bus.out_b),
    .valid   (bus.valid_b)
  );

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_register_file                                             |
// | Purpose : Self-checking bench for register_file with an array-based    |
// |           reference model; honours REGISTER_FILE_BYPASS_EN.            |
// | Ports   : none                                                         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_register_file;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 8;
  localparam int SOURCES = 4;
`ifdef REGISTER_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  register_file_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SOURCES(SOURCES)) bus ();

  register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SOURCES(SOURCES)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: storage contents plus expected port outputs.
  logic [WIDTH-1:0] m_data  [DEPTH];
  bit               m_valid [DEPTH];
  logic [WIDTH-1:0] exp_a, exp_b;
  bit               expv_a, expv_b;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i]  = '0;
      m_valid[i] = 1'b0;
    end
    exp_a = '0; exp_b = '0; expv_a = 1'b0; expv_b = 1'b0;
  endtask

  task automatic set_src(input int k, input logic [WIDTH-1:0] value);
    bus.in[k*WIDTH +: WIDTH] = value;
  endtask

  task automatic idle();
    bus.load  = 1'b0;
    bus.clear = 1'b0;
  endtask

  // Advance one clock edge; the model follows the written rules directly.
  task automatic tick();
    int               sel;
    logic [WIDTH-1:0] src;
    sel = int'(bus.select);
    src = bus.in[sel*WIDTH +: WIDTH];
    if (BYPASS && bus.load && bus.raddr_a == bus.waddr) begin
      exp_a = src; expv_a = 1'b1;
    end else begin
      exp_a  = m_data[bus.raddr_a];
      expv_a = (BYPASS && bus.clear) ? 1'b0 : m_valid[bus.raddr_a];
    end
    if (BYPASS && bus.load && bus.raddr_b == bus.waddr) begin
      exp_b = src; expv_b = 1'b1;
    end else begin
      exp_b  = m_data[bus.raddr_b];
      expv_b = (BYPASS && bus.clear) ? 1'b0 : m_valid[bus.raddr_b];
    end
    if (bus.clear) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    end
    if (bus.load) begin
      m_data[bus.waddr]  = src;
      m_valid[bus.waddr] = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.out_a !== 16'h0 || bus.out_b !== 16'h0 || bus.valid_a !== 1'b0 || bus.valid_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial out_a=%h out_b=%h va=%b vb=%b required all 0",
               bus.out_a, bus.out_b, bus.valid_a, bus.valid_b);
    end
    @(negedge clock);
    reset = 1'b0;
    bus.load = 1'b1; bus.select = 2'd0; set_src(0, 16'h1234); bus.waddr = 3'd1;
    tick();
    idle(); bus.raddr_a = 3'd1; bus.raddr_b = 3'd1;
    tick();
    checks++;
    if (bus.out_a !== 16'h1234 || bus.valid_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload out_a=%h va=%b required 1234 1", bus.out_a, bus.valid_a);
    end
    // Mid-cycle reset with a pending write to entry 4.
    bus.load = 1'b1; bus.select = 2'd1; set_src(1, 16'hABCD); bus.waddr = 3'd4;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (bus.out_a !== 16'h0 || bus.out_b !== 16'h0 || bus.valid_a !== 1'b0 || bus.valid_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_async out_a=%h out_b=%h va=%b vb=%b required all 0",
               bus.out_a, bus.out_b, bus.valid_a, bus.valid_b);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    // First edge after release is a normal write cycle.
    bus.load = 1'b1; bus.select = 2'd3; set_src(3, 16'h5A5A); bus.waddr = 3'd2;
    bus.raddr_a = 3'd4; bus.raddr_b = 3'd1;
    tick();
    checks++;
    if (bus.out_a !== 16'h0 || bus.valid_a !== 1'b0 || bus.out_b !== 16'h0 || bus.valid_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard out_a=%h va=%b out_b=%h vb=%b required all 0",
               bus.out_a, bus.valid_a, bus.out_b, bus.valid_b);
    end
    idle(); bus.raddr_a = 3'd2;
    tick();
    checks++;
    if (bus.out_a !== 16'h5A5A || bus.valid_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_edge out_a=%h va=%b required 5a5a 1", bus.out_a, bus.valid_a);
    end
  endtask

  task automatic test_write_read();
    bus.load = 1'b1; bus.select = 2'd2; set_src(2, 16'hBEEF); bus.waddr = 3'd5;
    bus.raddr_a = 3'd0;
    tick();
    idle(); bus.raddr_a = 3'd5;
    tick();
    checks++;
    if (bus.out_a !== 16'hBEEF || bus.valid_a !== 1'b1) begin
      errors++;
      $display("FAIL write_read out_a=%h va=%b required beef 1", bus.out_a, bus.valid_a);
    end
  endtask

  task automatic test_source_sweep();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) set_src(j, 16'h1111 * (j + 1));
      bus.load = 1'b1; bus.select = 2'(k); bus.waddr = 3'(k);
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      bus.raddr_a = 3'(k); bus.raddr_b = 3'(k);
      tick();
      checks++;
      if (bus.out_a !== 16'(16'h1111 * (k + 1)) || bus.out_b !== 16'(16'h1111 * (k + 1))
          || bus.valid_a !== 1'b1 || bus.valid_b !== 1'b1) begin
        errors++;
        $display("FAIL source_sweep[%0d] out_a=%h out_b=%h va=%b vb=%b required %h valid",
                 k, bus.out_a, bus.out_b, bus.valid_a, bus.valid_b, 16'(16'h1111 * (k + 1)));
      end
    end
  endtask

  task automatic test_collision();
    logic [WIDTH-1:0] want;
    bus.load = 1'b1; bus.select = 2'd0; set_src(0, 16'h00AA); bus.waddr = 3'd3;
    tick();
    bus.select = 2'd1; set_src(1, 16'h0055); bus.waddr = 3'd3; bus.raddr_a = 3'd3;
    tick();
    want = BYPASS ? 16'h0055 : 16'h00AA;
    checks++;
    if (bus.out_a !== want || bus.valid_a !== 1'b1) begin
      errors++;
      $display("FAIL collision out_a=%h va=%b required %h 1", bus.out_a, bus.valid_a, want);
    end
    idle();
    tick();
    checks++;
    if (bus.out_a !== 16'h0055) begin
      errors++;
      $display("FAIL collision_after out_a=%h required 0055", bus.out_a);
    end
  endtask

  task automatic test_clear();
    for (int e = 0; e < DEPTH; e++) begin
      bus.load = 1'b1; bus.select = 2'(e % 4); set_src(e % 4, 16'hC000 + 16'(e)); bus.waddr = 3'(e);
      tick();
    end
    bus.load = 1'b1; bus.clear = 1'b1; bus.select = 2'd2; set_src(2, 16'h6666); bus.waddr = 3'd6;
    bus.raddr_a = 3'd2; bus.raddr_b = 3'd6;
    tick();
    checks++;
    if (bus.out_a !== exp_a || bus.valid_a !== expv_a || bus.out_b !== exp_b || bus.valid_b !== expv_b) begin
      errors++;
      $display("FAIL clear_cycle out_a=%h va=%b out_b=%h vb=%b required %h %b %h %b",
               bus.out_a, bus.valid_a, bus.out_b, bus.valid_b, exp_a, expv_a, exp_b, expv_b);
    end
    idle();
    for (int e = 0; e < DEPTH; e++) begin
      bus.raddr_a = 3'(e);
      tick();
      checks++;
      if (bus.valid_a !== (e == 6) || bus.out_a !== exp_a) begin
        errors++;
        $display("FAIL clear_entry[%0d] out_a=%h va=%b required %h %b",
                 e, bus.out_a, bus.valid_a, exp_a, (e == 6));
      end
    end
    bus.raddr_b = 3'd2;
    tick();
    checks++;
    if (bus.out_b !== 16'hC002 || bus.valid_b !== 1'b0) begin
      errors++;
      $display("FAIL clear_keep_data out_b=%h vb=%b required c002 0", bus.out_b, bus.valid_b);
    end
  endtask

  task automatic test_dual_port();
    bus.load = 1'b1; bus.select = 2'd3; set_src(3, 16'h7777); bus.waddr = 3'd7;
    bus.raddr_a = 3'd0; bus.raddr_b = 3'd1;
    tick();
    idle(); bus.raddr_a = 3'd7; bus.raddr_b = 3'd7;
    tick();
    checks++;
    if (bus.out_a !== 16'h7777 || bus.out_b !== 16'h7777 || bus.valid_a !== 1'b1 || bus.valid_b !== 1'b1) begin
      errors++;
      $display("FAIL dual_port out_a=%h out_b=%h va=%b vb=%b required 7777 7777 1 1",
               bus.out_a, bus.out_b, bus.valid_a, bus.valid_b);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.load    = ($urandom_range(0, 1) == 1);
      bus.clear   = ($urandom_range(0, 9) == 0);
      bus.select  = 2'($urandom_range(0, SOURCES - 1));
      bus.in      = {$urandom(), $urandom()};
      bus.waddr   = 3'($urandom_range(0, DEPTH - 1));
      bus.raddr_a = 3'($urandom_range(0, DEPTH - 1));
      bus.raddr_b = ($urandom_range(0, 3) == 0) ? bus.waddr : 3'($urandom_range(0, DEPTH - 1));
      tick();
      checks++;
      if (bus.out_a !== exp_a || bus.valid_a !== expv_a) begin
        errors++;
        $display("FAIL random_a[%0d] out_a=%h va=%b required %h %b", n, bus.out_a, bus.valid_a, exp_a, expv_a);
      end
      checks++;
      if (bus.out_b !== exp_b || bus.valid_b !== expv_b) begin
        errors++;
        $display("FAIL random_b[%0d] out_b=%h vb=%b required %h %b", n, bus.out_b, bus.valid_b, exp_b, expv_b);
      end
    end
    idle();
  endtask

  initial begin
    reset       = 1'b1;
    bus.load    = 1'b0;
    bus.clear   = 1'b0;
    bus.select  = '0;
    bus.in      = '0;
    bus.waddr   = '0;
    bus.raddr_a = '0;
    bus.raddr_b = '0;
    model_reset();
    #13;
    test_reset();
    test_write_read();
    test_source_sweep();
    test_collision();
    test_clear();
    test_dual_port();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of storage entries; power of two, at least 2.
REQ-003 SHALL have parameter SOURCES, default 4, number of write-data sources; power of two, at least 2.
REQ-004 SHALL have derived constants AW = log2(DEPTH) and SW = log2(SOURCES).
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 load  input  1  write enable for the current cycle.
REQ-008 select  input  SW  write source index.
REQ-009 in  input  SOURCES*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-010 waddr  input  AW  write entry index.
REQ-011 clear  input  1  synchronous invalidate of all entries.
REQ-012 raddr_a, raddr_b  input  AW each  read entry indices.
REQ-013 out_a, out_b  output  WIDTH each  registered read data.
REQ-014 valid_a, valid_b  output  1 each  registered valid flag of the entry read.

Function
REQ-015 On a rising edge with load=1, entry[waddr] SHALL take source[select] and its valid bit SHALL set.
REQ-016 With load=0, storage SHALL hold its value.
REQ-017 clear=1 SHALL reset every valid bit at the edge; data contents SHALL be retained.
REQ-018 With clear=1 and load=1 in the same cycle, every entry SHALL end invalid except entry[waddr], which SHALL be written and valid.
REQ-019 Each read port SHALL have 1-cycle latency: out_x and valid_x at edge t+1 SHALL reflect entry[raddr_x] sampled at edge t.
REQ-020 Both read ports SHALL operate independently and may address the same entry.
REQ-021 A read of an invalid entry SHALL return valid_x=0; out_x SHALL be the stored data, which is not forced to zero.
REQ-022 All indices are in range by construction; no wrap or overflow handling is required.
REQ-023 A read colliding with a same-cycle write SHALL behave as defined in the Configuration section.

Reset
REQ-024 Reset SHALL force all entries to 0, all valid bits to 0, out_a and out_b to 0, and valid_a and valid_b to 0, immediately and independently of the clock.
REQ-025 Reset asserted mid-operation SHALL take effect immediately; any write in that cycle SHALL be discarded.
REQ-026 After reset deasserts, the first edge SHALL behave as a normal cycle.

Configuration
REQ-027 Macro REGISTER_FILE_BYPASS_EN SHALL select read-during-write behaviour.
REQ-028 With the macro defined: when load=1 and raddr_x==waddr, out_x SHALL be source[select] at the next edge and valid_x SHALL be 1, giving write-through.
REQ-029 Without the macro: in the same case, out_x and valid_x SHALL show the pre-write contents, giving read-old.
REQ-030 With the macro defined and clear=1 but no write match, bypass SHALL report valid_x=0.

Structure
REQ-031 A shared package SHALL hold the default constants (WIDTH 16, DEPTH 8, SOURCES 4) and a log2 helper function.
REQ-032 A sub-module register_file_read_port SHALL implement one registered read port and its bypass compare; it SHALL be instantiated twice.
REQ-033 The source multiplexer SHALL be parametric with no fixed case list.

Verification
REQ-034 Reset: assert reset mid-cycle -> all outputs 0 immediately; all valid_x 0 after release.
REQ-035 Write/read: load=1, select=2, in2=16'hBEEF, waddr=5; next cycle raddr_a=5 -> out_a=16'hBEEF and valid_a=1 one edge later.
REQ-036 Source sweep: write sources 0..3 carrying 16'h1111 through 16'h4444 to entries 0..3; read back on both ports -> matching values on both ports.
REQ-037 Collision: entry 3 holds 16'h00AA; write 16'h0055 to entry 3 while raddr_a=3 -> out_a=16'h0055 with macro defined, 16'h00AA without.
REQ-038 Clear: fill all 8 entries, then clear=1 together with a write to entry 6 -> only valid for entry 6 reads 1; entry 2 keeps its data with valid=0.
REQ-039 Dual port: raddr_a=raddr_b=7 after writing 16'h7777 -> both ports return 16'h7777 with valid=1 in the same cycle.
